// File: rtl/hex_display_scan_if.sv
// Display bus for hex_display_scan: value/enable in, multiplexed anodes and segments out.
interface hex_display_scan_if #(
    parameter int N = 8
);
    localparam int D = (N + 3) / 4;

    logic [N-1:0] value;
    logic         enable;
    logic [D-1:0] an;
    logic [6:0]   seg;

    modport master (output value, enable, input an, seg);
    modport slave  (input value, enable, output an, seg);
endinterface

// File: rtl/hex_display_scan.sv
// Time-multiplexed hex display driver with frame-coherent value snapshot.
// Optional leading-zero blanking when LEADING_ZERO_BLANK_EN is defined.
module hex_display_scan #(
    parameter int N           = 8,
    parameter int REFRESH_DIV = 50000
) (
    input logic                clk,
    input logic                reset,
    hex_display_scan_if.slave  bus
);
    localparam int D  = (N + 3) / 4;
    localparam int SW = 4 * D;
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] CntLast = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IdxLast = IW'(D - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [SW-1:0] snap_q, snap_d;
    logic [D-1:0]  an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          tick, wrap;
    logic [3:0]    nibble;
    logic          blank_digit;
    logic [6:0]    glyph;

    always_comb begin
        tick   = (cnt_q == CntLast);
        wrap   = tick && (idx_q == IdxLast);
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        idx_d  = idx_q;
        snap_d = snap_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        // Snapshot only at frame boundary so a frame never mixes two values.
        if (wrap) begin
            snap_d = SW'(bus.value);
        end
    end

    always_comb begin
        nibble      = 4'h0;
        blank_digit = 1'b0;
        for (int k = 0; k < D; k++) begin
            if (IW'(k) == idx_q) begin
                nibble = snap_q[4*k +: 4];
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        // Digit is a leading zero when it and every higher nibble are zero.
        blank_digit = (idx_q != '0);
        for (int k = 0; k < D; k++) begin
            if ((k >= int'(32'(idx_q))) && (snap_q[4*k +: 4] != 4'h0)) begin
                blank_digit = 1'b0;
            end
        end
`endif
    end

    always_comb begin
        glyph = 7'h7F;
        case (nibble)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
            default: glyph = 7'h7F;
        endcase
    end

    always_comb begin
        an_d  = '1;
        seg_d = 7'h7F;
        if (bus.enable && !blank_digit) begin
            an_d  = ~(D'(1) << idx_q);
            seg_d = glyph;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            snap_q <= '0;
            an_q   <= '1;
            seg_q  <= 7'h7F;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan (N=8, REFRESH_DIV=4): directed steps plus random value/enable
// traffic against a cycle-count based reference model.
module tb_hex_display_scan;
    localparam int N = 8;
    localparam int R = 4;
    localparam int D = 2;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit Lzb = 1'b1;
`else
    localparam bit Lzb = 1'b0;
`endif

    logic clk;
    logic reset;
    int   total;
    int   passed;
    int unsigned t;       // edges since reset release
    int unsigned snap_m;  // value captured at the last frame boundary

    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    hex_display_scan_if #(.N(N)) bus ();

    hex_display_scan #(.N(N), .REFRESH_DIV(R)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] expv);
        total++;
        assert (got === expv) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, expv);
    endtask

    // One clock: predict outputs from the pre-edge model state, advance model, compare.
    task automatic step();
        logic [7:0] ea;
        logic [7:0] es;
        int unsigned k;
        int unsigned upper;
        ea = 8'h03;
        es = 8'h7F;
        if (!reset) begin
            k     = (t / R) % D;
            upper = snap_m >> (4 * k);
            if (bus.enable && !(Lzb && k > 0 && upper == 0)) begin
                ea = 8'h03 & ~(8'd1 << k);
                es = {1'b0, glyph_tab[upper & 15]};
            end
        end
        if (reset) begin
            t      = 0;
            snap_m = 0;
        end else begin
            if (t % (D * R) == D * R - 1) snap_m = 32'(bus.value);
            t++;
        end
        @(posedge clk);
        #1;
        chk("model_an", 8'(bus.an), ea);
        chk("model_seg", {1'b0, bus.seg}, es);
    endtask

    initial begin
        total      = 0;
        passed     = 0;
        t          = 0;
        snap_m     = 0;
        reset      = 1'b1;
        bus.value  = '0;
        bus.enable = 1'b0;
        #3;
        chk("reset_an", 8'(bus.an), 8'h03);
        chk("reset_seg", {1'b0, bus.seg}, 8'h7F);

        // Inputs toggling under reset must not reach the outputs.
        for (int i = 0; i < 6; i++) begin
            bus.value  = 8'($urandom);
            bus.enable = (i % 2 == 1);
            step();
        end

        // Release: zeros until the first wrap, then 3A shown digit 0 first.
        reset      = 1'b0;
        bus.value  = 8'h3A;
        bus.enable = 1'b1;
        repeat (8) step();
        step();
        chk("first_d0_an", 8'(bus.an), 8'h02);
        chk("first_d0_seg", {1'b0, bus.seg}, 8'h08);
        repeat (3) step();
        step();
        chk("first_d1_an", 8'(bus.an), 8'h01);
        chk("first_d1_seg", {1'b0, bus.seg}, 8'h30);

        // Value change mid-frame must not tear the current frame.
        bus.value = 8'h5C;
        repeat (3) begin
            step();
            chk("no_tear_seg", {1'b0, bus.seg}, 8'h30);
        end
        step();
        chk("new_d0_seg", {1'b0, bus.seg}, 8'h46);
        repeat (3) step();
        step();
        chk("new_d1_an", 8'(bus.an), 8'h01);
        chk("new_d1_seg", {1'b0, bus.seg}, 8'h12);

        // Enable dropped mid-digit: dark, scan keeps running.
        bus.enable = 1'b0;
        step();
        chk("dark_an", 8'(bus.an), 8'h03);
        repeat (2) step();
        bus.enable = 1'b1;
        step();
        chk("resume_an", 8'(bus.an), 8'h02);

        // Leading zero on digit 1.
        bus.value = 8'h05;
        repeat (7) step();
        step();
        chk("lz_d0_an", 8'(bus.an), 8'h02);
        chk("lz_d0_seg", {1'b0, bus.seg}, 8'h12);
        repeat (3) step();
        step();
`ifdef LEADING_ZERO_BLANK_EN
        chk("lz_d1_an", 8'(bus.an), 8'h03);
        chk("lz_d1_seg", {1'b0, bus.seg}, 8'h7F);
`else
        chk("lz_d1_an", 8'(bus.an), 8'h01);
        chk("lz_d1_seg", {1'b0, bus.seg}, 8'h40);
`endif

        // Random value every cycle, enable mostly on.
        for (int i = 0; i < 300; i++) begin
            bus.value  = 8'($urandom);
            bus.enable = ($urandom_range(0, 9) != 0);
            step();
        end

        // Async reset landing at cnt=2, idx=1, between clock edges.
        bus.enable = 1'b1;
        for (int i = 0; i < 16 && (t % (D * R) != 6); i++) step();
        chk("pre_reset_phase", 8'(t % (D * R)), 8'd6);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_an", 8'(bus.an), 8'h03);
        chk("async_reset_seg", {1'b0, bus.seg}, 8'h7F);
        repeat (2) step();
        reset     = 1'b0;
        bus.value = 8'hE7;
        repeat (4) step();
        chk("post_reset_d0_an", 8'(bus.an), 8'h02);
        step();
        chk("post_reset_tick_an", 8'(bus.an), 8'h01);
        repeat (12) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
